priority_dec2_4_pipe: RTL
=========================

PRIORITY_DEC2_4_PIPE -- requirements
Module: priority_dec2_4_pipe

Interface
REQ-001 Parameter CNT_W, default 8: width of each per-line hit counter (used only with the Configuration feature).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  decode enable, sampled with in_code on accept; en=0 decodes to 4'b0000.
REQ-005 in_code  input  2  encoded index {O1,O0}, same bit order as the team's 4-to-2 priority encoder output.
REQ-006 in_valid  input  1  producer has a code on in_code/en.
REQ-007 in_ready  output  1  block can accept a code this cycle.
REQ-008 out_onehot  output  4  decoded one-hot word at head of buffer; bit i = line Ii.
REQ-009 out_valid  output  1  out_onehot holds a valid entry.
REQ-010 out_ready  input  1  consumer takes the head entry this cycle.
REQ-011 occupancy  output  2  number of buffered entries, 0..2.
REQ-012 hit_cnt  output  4*CNT_W  packed per-line hit counters, line i at bits [i*CNT_W +: CNT_W] (feature-dependent).
REQ-013 clr_cnt  input  1  synchronous clear of all hit counters (feature-dependent).

Function
REQ-014 Accept occurs when in_valid=1 and in_ready=1 at a rising edge; push value = en ? (4'b0001 << in_code) : 4'b0000.
REQ-015 Buffer is a 2-entry FIFO; in_ready = (occupancy != 2), independent of out_ready and in_valid.
REQ-016 out_valid = (occupancy != 0); out_onehot = head entry when out_valid=1, 4'b0000 when empty.
REQ-017 Pop occurs when out_valid=1 and out_ready=1 at a rising edge.
REQ-018 Latency: an entry accepted at edge N appears on out_onehot/out_valid after edge N (visible in cycle N+1) when buffer was empty; no combinational in-to-out path.
REQ-019 Simultaneous push and pop at occupancy 1: occupancy stays 1, new entry becomes head after the edge.
REQ-020 At occupancy 2, in_ready=0; a pop that edge drops occupancy to 1 and the push is not taken.
REQ-021 At occupancy 0, out_ready is ignored; occupancy never underflows or overflows.
REQ-022 Order preserved: entries leave in acceptance order; read/write pointers wrap modulo 2.
REQ-023 Entry contents and out_onehot are held stable while out_valid=1 and out_ready=0.

Reset
REQ-024 While rst_n=0 at a rising edge: occupancy=0, pointers=0, out_valid=0, out_onehot=4'b0000, in_ready=1 after the edge, hit counters=0.
REQ-025 Reset mid-operation discards all buffered entries; an accept presented in the same cycle as reset is dropped.

Configuration
REQ-026 Macro PRIORITY_DEC_HIT_CNT_EN defined: hit_cnt and clr_cnt ports exist; on each pop, hit_cnt[i] increments for every set bit i of the popped word, saturating at 2^CNT_W-1.
REQ-027 With the macro, clr_cnt=1 clears all counters and takes priority over a same-edge increment; rst_n has priority over clr_cnt.
REQ-028 Macro undefined: hit_cnt, clr_cnt and all counter logic are absent; remaining behaviour is identical.

Structure
REQ-029 A shared package holds the code-width constant (2), line-count constant (4), FIFO depth (2) and the one-hot word typedef.
REQ-030 One sub-module, dec2_4_core, is combinational: {en, in_code} -> 4-bit one-hot; FIFO and counters stay in the top.

Verification
REQ-031 Reset then push code=2'b10, en=1, out_ready=1 -> next cycle out_valid=1, out_onehot=4'b0100; following cycle out_valid=0.
REQ-032 out_ready=0, push codes 3 then 0 -> occupancy=2, in_ready=0, out_onehot=4'b1000 held; third push ignored; release -> 4'b1000, then 4'b0001.
REQ-033 occupancy=1 with simultaneous push code 1 and pop -> occupancy stays 1, out_onehot becomes 4'b0010.
REQ-034 Push with en=0, code=3 -> out_valid=1, out_onehot=4'b0000.
REQ-035 Fill buffer, assert rst_n=0 one cycle -> occupancy=0, out_valid=0, in_ready=1.
REQ-036 With PRIORITY_DEC_HIT_CNT_EN, CNT_W=2: pop code 1 five times -> hit_cnt line1=3 (saturated), others 0; clr_cnt with same-edge pop -> all 0.

Source files
------------

// File: rtl/priority_dec2_4_pipe_pkg.sv
// Shared constants and types for the 2-to-4 priority decoder pipeline.
// The code width, line count and buffer depth are fixed here so the
// decoder core, the buffer and the bench all agree on them.
package priority_dec2_4_pipe_pkg;

    localparam int CODE_W = 2;
    localparam int LINES  = 4;
    localparam int DEPTH  = 2;
    localparam int PTR_W  = 1;
    localparam int OCC_W  = 2;

    localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
    localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

    typedef logic [LINES-1:0] onehot_t;

endpackage

// File: rtl/priority_dec2_4_pipe_dec2_4_core.sv
// Combinational 2-to-4 decoder with enable.
// Bit i of the result is line Ii; a disabled decode yields all zeros.
module dec2_4_core
    import priority_dec2_4_pipe_pkg::*;
(
    input  logic              en,
    input  logic [CODE_W-1:0] in_code,
    output onehot_t           onehot
);

    // Shift a single set bit into the position named by the code.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = onehot_t'(1) << in_code;
        end
    end

endmodule

// File: rtl/priority_dec2_4_pipe.sv
// Pipelined 2-to-4 decoder: each accepted code is decoded and pushed into a
// two-entry FIFO with valid/ready handshakes on both sides.
// Optional feature macro: PRIORITY_DEC_HIT_CNT_EN adds per-line saturating
// hit counters (hit_cnt/clr_cnt ports) updated whenever an entry is popped.
module priority_dec2_4_pipe
    import priority_dec2_4_pipe_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [1:0]             in_code,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [3:0]             out_onehot,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef PRIORITY_DEC_HIT_CNT_EN
    output logic [4*CNT_W-1:0]     hit_cnt,
    input  logic                   clr_cnt,
`endif
    output logic [1:0]             occupancy
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    onehot_t            push_word;
    onehot_t            head_word;
    logic               push;
    logic               pop;

    onehot_t            mem_q [DEPTH];
    onehot_t            mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   occ_d;

    dec2_4_core u_core (
        .en      (en),
        .in_code (in_code),
        .onehot  (push_word)
    );

    // Handshake status: ready depends only on fill level, never on out_ready.
    always_comb begin
        in_ready   = (occ_q != OCC_FULL);
        out_valid  = (occ_q != OCC_EMPTY);
        head_word  = mem_q[rd_ptr_q];
        out_onehot = out_valid ? head_word : '0;
        occupancy  = occ_q;
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready;
    end

    // Next FIFO state: write at wr_ptr on push, advance rd_ptr on pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // FIFO registers; reset discards contents and any same-edge accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= OCC_EMPTY;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

`ifdef PRIORITY_DEC_HIT_CNT_EN
    logic [CNT_W-1:0] cnt_q [LINES];
    logic [CNT_W-1:0] cnt_d [LINES];

    // Counter update: clear wins over a pop, each popped bit bumps its line.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            for (int i = 0; i < LINES; i++) begin
                cnt_d[i] = '0;
            end
        end else if (pop) begin
            for (int i = 0; i < LINES; i++) begin
                if (head_word[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Counter registers; reset has priority over clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Pack the per-line counters, line i in slice i.
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < LINES; i++) begin
            hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule
